// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_ranger
// Purpose  : Multi-channel ultrasonic ranging controller, Avalon-MM slave.
//            Scans the enabled channels round-robin. For each channel it
//            fires a trigger pulse and times the echo pulse in clk cycles.
//            It raises a level interrupt at the end of every scan.
// Ports    : clk, reset_n (async, active-low)
//            address/chipselect/write_n/writedata : Avalon-MM write side
//            readdata : combinational read data, zero wait states
//            echo_in  : raw asynchronous echo inputs, one per channel
//            trig_out : registered trigger outputs, one per channel
//            irq      : IRQ_EN & SCAN_DONE
// Options  : ULTRASONIC_MANUAL_EN adds the MANUAL trigger register at
//            address 3. It is ORed into trig_out.
// Revision : 1.0 - initial release
// ============================================================================
module ultrasonic_ranger #(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 24,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int GAP_CYCLES     = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [NUM_CH-1:0] echo_in,
    output logic [NUM_CH-1:0] trig_out,
    output logic              irq
);

    localparam int               c_CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] c_SAT = '1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_TRIG  = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_MEAS  = 3'd3;
    localparam logic [2:0] c_ST_STORE = 3'd4;
    localparam logic [2:0] c_ST_GAP   = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [c_CHW-1:0]  r_ch;
    logic [31:0]       r_cnt;        // TRIG / GAP phase counter
    logic [31:0]       r_tmo;        // timeout counter, WAIT_ECHO + MEASURE
    logic [CNT_W-1:0]  r_width;
    logic              r_to_flag;    // current measurement ended by timeout
    logic [NUM_CH-1:0] r_trig;
    logic [NUM_CH-1:0] r_echo_s1, r_echo_s2, r_echo_s3;
    logic              r_cont, r_irq_en;
    logic [NUM_CH-1:0] r_mask;
    logic              r_start_p, r_abort_p;
    logic              r_scan_done;
    logic [NUM_CH-1:0] r_done, r_tmo_st;
    logic [CNT_W-1:0]  r_result [NUM_CH];

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [2:0]        w_state_nxt;
    logic [c_CHW-1:0]  w_ch_nxt;
    logic              w_store, w_scan_end, w_timeout;
    logic              w_first_vld, w_next_vld;
    logic [c_CHW-1:0]  w_first_ch, w_next_ch;
    logic [NUM_CH-1:0] w_ch_oh, w_trig_nxt;
    logic              w_echo, w_echo_d, w_rise, w_fall, w_tmo_hit;
    logic              w_wr, w_wr_ctrl, w_wr_stat;
    logic              w_busy;
    logic              w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_ctrl = w_wr && (address == 4'd0);
    assign w_wr_stat = w_wr && (address == 4'd1);
    assign w_busy    = (r_state != c_ST_IDLE);
    assign w_unused  = &{1'b0, writedata};

    // The edge detector runs on the synchronised copy of each channel. The
    // stage 3 delay keeps edges clean across channel switches.
    assign w_echo    = r_echo_s2[r_ch];
    assign w_echo_d  = r_echo_s3[r_ch];
    assign w_rise    = w_echo & ~w_echo_d;
    assign w_fall    = ~w_echo & w_echo_d;
    assign w_tmo_hit = (r_tmo >= 32'(TIMEOUT_CYCLES - 1));

    // Lowest enabled channel, and lowest enabled channel above r_ch. The
    // live mask is used, so mid-scan edits affect only unselected channels.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_ch  = '0;
        w_next_vld  = 1'b0;
        w_next_ch   = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (r_mask[c]) begin
                w_first_vld = 1'b1;
                w_first_ch  = c_CHW'(c);
            end
            if (r_mask[c] && (c > int'(r_ch))) begin
                w_next_vld = 1'b1;
                w_next_ch  = c_CHW'(c);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_store     = 1'b0;
        w_scan_end  = 1'b0;
        w_timeout   = 1'b0;
        if (r_abort_p) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_start_p && w_first_vld) begin
                        w_state_nxt = c_ST_TRIG;
                        w_ch_nxt    = w_first_ch;
                    end
                end
                c_ST_TRIG: begin
                    if (r_cnt >= 32'(TRIG_CYCLES - 1)) begin
                        w_state_nxt = c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (w_tmo_hit) begin
                        w_state_nxt = c_ST_STORE;
                        w_timeout   = 1'b1;
                    end else if (w_rise) begin
                        w_state_nxt = c_ST_MEAS;
                    end
                end
                c_ST_MEAS: begin
                    if (w_tmo_hit) begin
                        w_state_nxt = c_ST_STORE;
                        w_timeout   = 1'b1;
                    end else if (w_fall) begin
                        w_state_nxt = c_ST_STORE;
                    end
                end
                c_ST_STORE: begin
                    w_store     = 1'b1;
                    w_state_nxt = c_ST_GAP;
                end
                c_ST_GAP: begin
                    if (r_cnt >= 32'(GAP_CYCLES - 1)) begin
                        if (w_next_vld) begin
                            w_state_nxt = c_ST_TRIG;
                            w_ch_nxt    = w_next_ch;
                        end else begin
                            w_scan_end = 1'b1;
                            if (r_cont && w_first_vld) begin
                                w_state_nxt = c_ST_TRIG;
                                w_ch_nxt    = w_first_ch;
                            end else begin
                                w_state_nxt = c_ST_IDLE;
                            end
                        end
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ch_oh    = '0;
        w_trig_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_ch_oh[c]    = (r_ch == c_CHW'(c));
            w_trig_nxt[c] = (w_state_nxt == c_ST_TRIG) && (w_ch_nxt == c_CHW'(c));
        end
    end

    // ------------------------------------------------------------------
    // FSM state register and measurement datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_ST_IDLE;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_width   <= '0;
            r_to_flag <= 1'b0;
            r_trig    <= '0;
            r_echo_s1 <= '0;
            r_echo_s2 <= '0;
            r_echo_s3 <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_trig    <= w_trig_nxt;
            r_echo_s1 <= echo_in;
            r_echo_s2 <= r_echo_s1;
            r_echo_s3 <= r_echo_s2;

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == c_ST_TRIG) || (r_state == c_ST_GAP)) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (r_state == c_ST_TRIG) begin
                r_tmo <= '0;
            end else if ((r_state == c_ST_WAIT) || (r_state == c_ST_MEAS)) begin
                r_tmo <= r_tmo + 32'd1;
            end

            if (w_timeout) begin
                r_width <= c_SAT;
            end else if ((r_state == c_ST_WAIT) && w_rise) begin
                r_width <= '0;
            end else if ((r_state == c_ST_MEAS) && w_echo && (r_width != c_SAT)) begin
                r_width <= r_width + 1'b1;
            end

            if (w_timeout) begin
                r_to_flag <= 1'b1;
            end else if (r_state == c_ST_TRIG) begin
                r_to_flag <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control, status and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cont      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_mask      <= '0;
            r_start_p   <= 1'b0;
            r_abort_p   <= 1'b0;
            r_scan_done <= 1'b0;
            r_done      <= '0;
            r_tmo_st    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_result[c] <= '0;
            end
        end else begin
            // START/ABORT act one edge after the write lands.
            r_start_p <= w_wr_ctrl & writedata[0];
            r_abort_p <= w_wr_ctrl & writedata[3];
            if (w_wr_ctrl) begin
                r_cont   <= writedata[1];
                r_irq_en <= writedata[2];
                r_mask   <= writedata[8 +: NUM_CH];
            end

            // W1C clear first, hardware set ORed on top so the set wins.
            r_scan_done <= (r_scan_done & ~(w_wr_stat & writedata[1])) | w_scan_end;
            r_done      <= (r_done & ~(w_wr_stat ? writedata[8 +: NUM_CH] : '0))
                           | (w_store ? w_ch_oh : '0);
            r_tmo_st    <= (r_tmo_st & ~(w_wr_stat ? writedata[16 +: NUM_CH] : '0))
                           | ((w_store && r_to_flag) ? w_ch_oh : '0);

            if (w_store) begin
                r_result[r_ch] <= r_width;
            end
        end
    end

`ifdef ULTRASONIC_MANUAL_EN
    logic [NUM_CH-1:0] r_manual;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_manual <= '0;
        end else if (w_wr && (address == 4'd3)) begin
            r_manual <= writedata[NUM_CH-1:0];
        end
    end

    assign trig_out = r_trig | r_manual;
`else
    assign trig_out = r_trig;
`endif

    assign irq = r_irq_en & r_scan_done;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            4'd0: begin
                readdata[1]            = r_cont;
                readdata[2]            = r_irq_en;
                readdata[8 +: NUM_CH]  = r_mask;
            end
            4'd1: begin
                readdata[0]            = w_busy;
                readdata[1]            = r_scan_done;
                readdata[8 +: NUM_CH]  = r_done;
                readdata[16 +: NUM_CH] = r_tmo_st;
            end
            4'd2: readdata[c_CHW-1:0] = r_ch;
`ifdef ULTRASONIC_MANUAL_EN
            4'd3: readdata[NUM_CH-1:0] = r_manual;
`endif
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (address == 4'(4 + c)) begin
                        readdata = 32'(r_result[c]);
                    end
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : tb_ultrasonic_ranger
// Purpose  : Directed self-checking bench for ultrasonic_ranger. Expected
//            echo widths are queued when an echo is driven. They are popped
//            when the DUT flags DONE for that channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_ranger;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [3:0]        address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] echo_in = '0;
    logic [NUM_CH-1:0] trig_out;
    logic              irq;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    ultrasonic_ranger #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .TRIG_CYCLES    (10),
        .TIMEOUT_CYCLES (1000),
        .GAP_CYCLES     (20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .echo_in    (echo_in),
        .trig_out   (trig_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Waits for trig_out[ch] to go high, then counts the cycles it stays high.
    task automatic wait_trig(input int ch, output int hi);
        int t;
        t  = 0;
        hi = 0;
        while ((trig_out[ch] !== 1'b1) && (t < 500)) begin
            @(negedge clk);
            t++;
        end
        while ((trig_out[ch] === 1'b1) && (hi < 500)) begin
            @(negedge clk);
            hi++;
        end
    endtask

    task automatic pulse_echo(input int ch, input int w);
        cycles(5);
        echo_in[ch] = 1'b1;
        cycles(w);
        echo_in[ch] = 1'b0;
        exp_q.push_back(w);
    endtask

    // Waits for DONE[ch], then pops the scoreboard and compares RESULT[ch].
    task automatic check_result(input int ch, input string tag, output int waited);
        logic [31:0] s;
        logic [31:0] r;
        int          e;
        waited = 0;
        rd(4'd1, s);
        while (!s[8+ch] && (waited < 3000)) begin
            @(negedge clk);
            waited++;
            rd(4'd1, s);
        end
        check({tag, "_done"}, {31'd0, s[8+ch]}, 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -100;
        rd(4'(4 + ch), r);
        check_range(tag, int'(r), e - 1, e + 1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int          t;
        t = 0;
        rd(4'd1, s);
        while (s[0] && (t < 1000)) begin
            @(negedge clk);
            t++;
            rd(4'd1, s);
        end
        check(tag, {31'd0, s[0]}, 32'd0);
    endtask

    task automatic wait_irq(input string tag);
        int t;
        t = 0;
        while ((irq !== 1'b1) && (t < 300)) begin
            @(negedge clk);
            t++;
        end
        check(tag, {31'd0, irq}, 32'd1);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] r;
        int          hi;
        int          waited;
        int          t;

        #1 reset_n = 1'b0;
        cycles(3);
        check("rst_trig", {30'd0, trig_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd(4'd0, r); check("rst_ctrl", r, 32'd0);
        rd(4'd1, r); check("rst_status", r, 32'd0);
        rd(4'd2, r); check("rst_curch", r, 32'd0);
        rd(4'd4, r); check("rst_res0", r, 32'd0);
        rd(4'd5, r); check("rst_res1", r, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(2);

        // Two-channel scan with measured echoes
        wr(4'd0, 32'h0000_0301);
        wait_trig(0, hi);
        check("trig0_len", hi, 32'd10);
        pulse_echo(0, 300);
        check_result(0, "res0_300", waited);
        wait_trig(1, hi);
        check("trig1_len", hi, 32'd10);
        pulse_echo(1, 500);
        check_result(1, "res1_500", waited);
        wait_idle("scan1_idle");
        rd(4'd1, s);
        check("status_0302", s, 32'h0000_0302);
        check("irq_disabled", {31'd0, irq}, 32'd0);

        // Asynchronous reset in the middle of a trigger pulse
        wr(4'd0, 32'h0000_0301);
        t = 0;
        while ((trig_out[0] !== 1'b1) && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        cycles(3);
        check("pre_rst_trig", {30'd0, trig_out}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid_trig", {30'd0, trig_out}, 32'd0);
        rd(4'd1, s); check("rstmid_status", s, 32'd0);
        rd(4'd4, r); check("rstmid_res0", r, 32'd0);
        rd(4'd0, r); check("rstmid_ctrl", r, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(3);
        rd(4'd1, s); check("post_rst_idle", s, 32'd0);

        // Channel 0 never echoes: timeout, then channel 1 measured
        wr(4'd0, 32'h0000_0301);
        wait_trig(0, hi);
        exp_q.push_back(32'hFFFF);
        check_result(0, "tmo_res0", waited);
        check_range("tmo_latency", waited, 996, 1006);
        wait_trig(1, hi);
        check("tmo_next_trig1", hi, 32'd10);
        pulse_echo(1, 200);
        check_result(1, "res1_200", waited);
        rd(4'd1, s);
        check("tmo_bits", {30'd0, s[17:16]}, 32'd1);
        wait_idle("tmo_scan_idle");

        // W1C of every status flag
        wr(4'd1, 32'h0003_0303);
        rd(4'd1, s); check("w1c_all", s, 32'd0);

        // Continuous scanning with interrupt
        wr(4'd0, 32'h0000_0107);
        wait_trig(0, hi);
        pulse_echo(0, 100);
        check_result(0, "cont_scan1", waited);
        wait_irq("irq_scan1");
        wr(4'd1, 32'h0000_0002);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        wr(4'd1, 32'h0000_0100);
        wait_trig(0, hi);
        pulse_echo(0, 150);
        check_result(0, "cont_scan2", waited);
        wait_irq("irq_scan2");
        wr(4'd0, 32'h0000_0104);
        wr(4'd1, 32'h0000_0102);
        check("irq_cleared2", {31'd0, irq}, 32'd0);
        wait_trig(0, hi);
        pulse_echo(0, 50);
        check_result(0, "cont_scan3", waited);
        wait_idle("cont_stop_idle");
        check("irq_scan3", {31'd0, irq}, 32'd1);
        cycles(40);
        rd(4'd1, s); check("cont_stays_idle", {31'd0, s[0]}, 32'd0);

        // ABORT while measuring
        wr(4'd1, 32'h0003_0303);
        wr(4'd0, 32'h0000_0101);
        wait_trig(0, hi);
        cycles(5);
        echo_in[0] = 1'b1;
        cycles(20);
        rd(4'd1, s); check("meas_busy", {31'd0, s[0]}, 32'd1);
        wr(4'd0, 32'h0000_0008);
        @(negedge clk);
        rd(4'd1, s); check("abort_status", s, 32'd0);
        check("abort_trig", {30'd0, trig_out}, 32'd0);
        cycles(10);
        echo_in[0] = 1'b0;
        cycles(10);
        rd(4'd4, r); check_range("abort_res0_kept", int'(r), 49, 51);
        rd(4'd1, s); check("abort_no_done", s, 32'd0);

        // ABORT beats START in one write; START with empty mask is ignored
        wr(4'd0, 32'h0000_0109);
        cycles(2);
        rd(4'd1, s); check("abort_prio", {31'd0, s[0]}, 32'd0);
        wr(4'd0, 32'h0000_0001);
        cycles(2);
        rd(4'd1, s); check("zero_mask_start", {31'd0, s[0]}, 32'd0);

`ifdef ULTRASONIC_MANUAL_EN
        wr(4'd3, 32'h0000_0002);
        check("manual_trig", {30'd0, trig_out}, 32'd2);
        rd(4'd3, r); check("manual_rd", r, 32'd2);
        wr(4'd3, 32'h0000_0000);
        check("manual_off", {30'd0, trig_out}, 32'd0);
`else
        wr(4'd3, 32'h0000_0002);
        check("no_manual_trig", {30'd0, trig_out}, 32'd0);
        rd(4'd3, r); check("no_manual_rd", r, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ultrasonic_ranger.md
# ultrasonic_ranger

Parametrised multi-channel ultrasonic ranging controller on the Avalon-MM bus. It supersedes the bare 2-bit trigger output port used for the ultrasonic sensors. The block generates trigger pulses and times echo pulses in hardware, scanning enabled channels round-robin. It stores a per-channel echo width in clock cycles and raises an interrupt at the end of each scan.

## Interface
- NUM_CH, 2: sensor channels, legal 1..8.
- CNT_W, 24: echo-width counter/result width, legal 16..32.
- TRIG_CYCLES, 500: trigger pulse length in clk cycles (10 us @ 50 MHz).
- TIMEOUT_CYCLES, 1900000: maximum cycles from trigger end to echo fall (38 ms).
- GAP_CYCLES, 50000: idle cycles between channels (1 ms).
- clk  in  1  system clock; the single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  4  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address, zero-wait.
- echo_in  in  NUM_CH  raw echo inputs, asynchronous.
- trig_out  out  NUM_CH  trigger outputs, registered.
- irq  out  1  level interrupt.

## Operation
- Register map, with unlisted or unused bits reading 0:
  - 0 CTRL: bit0 START (write-only, pulse); bit1 CONT; bit2 IRQ_EN; bit3 ABORT (write-only, pulse); bits[8+NUM_CH-1:8] channel enable mask.
  - 1 STATUS: bit0 BUSY (RO); bit1 SCAN_DONE (W1C); bits[8+c] DONE[c] (W1C); bits[16+c] TMO[c] (W1C).
  - 2 CUR_CH: current channel index (RO).
  - 4+c RESULT[c]: echo width in cycles, zero-extended to 32 bits (RO).
- Echo inputs pass through a 2-FF synchroniser. Measurements use the synchronised echo only.
- FSM states:
  - IDLE: a START write with a nonzero mask goes to TRIG on the lowest enabled channel. A zero mask, or a START while not IDLE, is ignored.
  - TRIG: trig_out[ch] is held high for TRIG_CYCLES cycles, then the FSM goes to WAIT_ECHO and the timeout counter clears.
  - WAIT_ECHO: a synchronised rising edge goes to MEASURE with the width counter at 0.
  - MEASURE: the width counter increments each cycle while echo is high, saturating at 2^CNT_W-1. A falling edge goes to STORE.
  - STORE: writes RESULT[ch] and sets DONE[ch], then goes to GAP.
  - GAP: waits GAP_CYCLES, then selects the next enabled channel above ch and goes to TRIG. If no channel is left, scan end applies.
- Timeout: the counter runs in WAIT_ECHO and MEASURE. Reaching TIMEOUT_CYCLES forces STORE with RESULT = all-ones (2^CNT_W-1) and sets both TMO[ch] and DONE[ch].
- Scan end: SCAN_DONE is set. With CONT=1, the FSM returns to TRIG on the lowest enabled channel, using the mask sampled at that moment; with CONT=0 it returns to IDLE. Clearing CONT mid-scan completes the current scan, then the FSM idles.
- ABORT: from any state, the FSM goes to IDLE next edge and trig_out drops to 0. No RESULT or flag updates occur, and ABORT has priority over START in the same write.
- The mask is sampled when each channel is selected. Changing the mask mid-scan affects only the channels not yet selected.
- irq = IRQ_EN & SCAN_DONE.
- W1C versus hardware set in the same cycle: the set wins.
- BUSY = (state != IDLE).

## Timing
- Reset: the FSM is in IDLE.
- Reset values of all outputs and registers: trig_out=0, irq=0, CTRL=0, STATUS=0, CUR_CH=0, all RESULT=0, readdata=0 at address 0.
- An asynchronous reset mid-scan aborts immediately to these values.
- Write accepted at edge k (chipselect & ~write_n):
  - The register updates at k.
  - Pulse bits (START, ABORT) act at k+1.
- START accepted at edge k: trig_out[ch] is high in cycles k+1 .. k+TRIG_CYCLES.
- Echo latency: 2-cycle synchroniser.
  - Measured width equals the echo high time in cycles, within ±1.
  - RESULT and DONE become visible 1 cycle after the synchronised fall.
- Reads have zero latency. A read in the same cycle as STORE returns the old RESULT.

## Configuration
- ULTRASONIC_MANUAL_EN defined:
  - Address 3 is a MANUAL register, bits[NUM_CH-1:0], R/W, reset 0.
  - trig_out = FSM trigger | MANUAL, giving legacy software-driven triggering.
- Undefined: address 3 reads 0, writes are ignored, and trig_out is FSM-driven only.

## Test plan
Benches run with TRIG_CYCLES=10, TIMEOUT_CYCLES=1000, GAP_CYCLES=20, NUM_CH=2, CNT_W=16.
- Reset with trig toggling: assert reset_n=0 mid-TRIG -> trig_out=0, BUSY=0 and RESULT[0]=0 immediately.
- CTRL=0x0301 (mask 0b11, START), channel 0 echo high 300 cycles, channel 1 echo high 500 cycles:
  - trig_out[0] is high for exactly 10 cycles.
  - RESULT[0] = 300±1 and RESULT[1] = 500±1.
  - STATUS = 0x0302.
- Channel 0 echo never rises:
  - After 1000 cycles, RESULT[0] = 0xFFFF and TMO[0] = 1.
  - The scan proceeds to channel 1.
- CTRL=0x0107 (CONT, IRQ_EN, mask 0b01, START):
  - irq rises after the first scan.
  - Writing STATUS=0x2 drops irq, and the second scan sets it again.
- ABORT written in MEASURE -> IDLE next cycle, and RESULT and DONE are unchanged.
- With ULTRASONIC_MANUAL_EN defined: write 0x2 to address 3 -> trig_out=0b10 while IDLE, and a read of address 3 returns 0x2.
